// File: rtl/hs_fifo.sv
// hs_fifo: elastic req/ack buffer, consumer upstream and producer downstream, fully registered outputs
module hs_fifo #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int ptr_width  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [ptr_width:0]    count,
  output logic                  err
);
  localparam logic [ptr_width:0] full_c = (ptr_width+1)'(depth);
  logic [data_width-1:0] mem [depth];
  logic [ptr_width-1:0]  wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic                  req_l_q, req_l_d, ack_r_q, ack_r_d, err_q, err_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [ptr_width:0]    count_q, count_d;
  logic                  push, pop;
  assign push = ack_l & req_l_q;
  // pop looks only at registered count, so a word pushed this edge is never bypassed
  assign pop  = req_r & ~ack_r_q & (count_q != '0);
  always_comb begin
    req_l_d  = push ? 1'b0 : (!req_l_q && !ack_l && count_q < full_c) ? 1'b1 : req_l_q;
    ack_r_d  = pop;
    dout_d   = pop ? mem[rd_ptr_q] : dout_q;
    count_d  = count_q + (ptr_width+1)'(push) - (ptr_width+1)'(pop);
    err_d    = err_q | (ack_l & ~req_l_q);
    wr_ptr_d = push ? wr_ptr_q + ptr_width'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + ptr_width'(1) : rd_ptr_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_l_q  <= 1'b0;
      ack_r_q  <= 1'b0;
      dout_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      req_l_q  <= req_l_d;
      ack_r_q  <= ack_r_d;
      dout_q   <= dout_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= din;
  end
  assign req_l = req_l_q;
  assign ack_r = ack_r_q;
  assign dout  = dout_q;
  assign count = count_q;
  assign err   = err_q;
endmodule

// File: tb/tb_hs_fifo.sv
// tb_hs_fifo: directed checks on a depth-4 buffer, then a random soak on depth 4 and depth 8
module tb_hs_fifo;
  localparam int N = 5000;
  logic        clk = 1'b0, rst = 1'b1;
  logic        ack_l = 1'b0, req_r = 1'b0, req_l, ack_r, err;
  logic [31:0] din = '0, dout;
  logic [2:0]  count;
  logic        ack_l8 = 1'b0, req_r8 = 1'b0, req_l8, ack_r8, err8;
  logic [31:0] din8 = '0, dout8;
  logic [3:0]  count8;
  int checks = 0, passed = 0;
  int n4 = 0, n8 = 0, rx4 = 0, rx8 = 0;
  always #5 clk = ~clk;
  hs_fifo #(.data_width(32), .depth(4), .ptr_width(2)) u4 (
    .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din), .req_r(req_r),
    .ack_r(ack_r), .dout(dout), .count(count), .err(err));
  hs_fifo #(.data_width(32), .depth(8), .ptr_width(3)) u8 (
    .clk(clk), .rst(rst), .req_l(req_l8), .ack_l(ack_l8), .din(din8), .req_r(req_r8),
    .ack_r(ack_r8), .dout(dout8), .count(count8), .err(err8));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(input logic [31:0] v);
    int k = 0;
    while (!req_l && k < 20) begin
      tick;
      k++;
    end
    if (!req_l) check("push_req_l_timeout", {31'b0, req_l}, 1);
    ack_l = 1'b1;
    din = v;
    tick;
    ack_l = 1'b0;
  endtask
  task automatic pop_expect(input logic [31:0] v);
    int k = 0;
    req_r = 1'b1;
    do begin
      tick;
      k++;
    end while (!ack_r && k < 20);
    req_r = 1'b0;
    check("pop_ack", {31'b0, ack_r}, 1);
    check("pop_dout", dout, v);
  endtask
  initial begin
    tick;
    tick;
    check("rst_req_l", {31'b0, req_l}, 0);
    check("rst_ack_r", {31'b0, ack_r}, 0);
    check("rst_dout", dout, 0);
    check("rst_count", {29'b0, count}, 0);
    check("rst_err", {31'b0, err}, 0);
    rst = 1'b0;
    tick;
    check("rel_req_l", {31'b0, req_l}, 1);
    req_r = 1'b1;
    push_word(5);
    check("pt_count1", {29'b0, count}, 1);
    check("pt_no_early_ack", {31'b0, ack_r}, 0);
    tick;
    check("pt_ack", {31'b0, ack_r}, 1);
    check("pt_dout", dout, 5);
    check("pt_count0", {29'b0, count}, 0);
    req_r = 1'b0;
    tick;
    check("pt_ack_pulse", {31'b0, ack_r}, 0);
    check("pt_dout_hold", dout, 5);
    for (int v = 10; v < 14; v++) push_word(v);
    repeat (3) tick;
    check("fill_count", {29'b0, count}, 4);
    check("fill_req_l", {31'b0, req_l}, 0);
    check("fill_err", {31'b0, err}, 0);
    req_r = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      check("drain_ack", {31'b0, ack_r}, 1);
      check("drain_dout", dout, 10 + i);
      tick;
      check("drain_gap", {31'b0, ack_r}, 0);
    end
    req_r = 1'b0;
    check("drain_count", {29'b0, count}, 0);
    push_word(30);
    push_word(31);
    tick;
    check("cc_req_l", {31'b0, req_l}, 1);
    ack_l = 1'b1;
    din = 20;
    req_r = 1'b1;
    tick;
    ack_l = 1'b0;
    req_r = 1'b0;
    check("cc_count", {29'b0, count}, 2);
    check("cc_ack", {31'b0, ack_r}, 1);
    check("cc_dout", dout, 30);
    pop_expect(31);
    pop_expect(20);
    check("cc_count0", {29'b0, count}, 0);
    for (int v = 40; v < 44; v++) push_word(v);
    ack_l = 1'b1;
    din = 99;
    tick;
    ack_l = 1'b0;
    check("perr_err", {31'b0, err}, 1);
    check("perr_count", {29'b0, count}, 4);
    tick;
    check("perr_req_l", {31'b0, req_l}, 0);
    for (int v = 40; v < 44; v++) pop_expect(v);
    check("perr_sticky", {31'b0, err}, 1);
    check("perr_count0", {29'b0, count}, 0);
    for (int v = 50; v < 53; v++) push_word(v);
    check("mid_count3", {29'b0, count}, 3);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req_l", {31'b0, req_l}, 0);
    check("arst_ack_r", {31'b0, ack_r}, 0);
    check("arst_count", {29'b0, count}, 0);
    check("arst_err", {31'b0, err}, 0);
    check("arst_dout", dout, 0);
    tick;
    rst = 1'b0;
    tick;
    check("arst_rel_req_l", {31'b0, req_l}, 1);
    fork
      for (int c = 0; c < 60000 && (n4 < N || ack_l); c++) begin
        @(posedge clk);
        #1;
        if (ack_l) ack_l = 1'b0;
        else if (req_l && n4 < N && $urandom_range(99) >= 30) begin
          ack_l = 1'b1;
          din = n4;
          n4++;
        end
      end
      for (int c = 0; c < 60000 && rx4 < N; c++) begin
        @(posedge clk);
        #1;
        if (ack_r) begin
          check("soak4_dout", dout, rx4);
          rx4++;
        end
        req_r = rx4 < N && $urandom_range(99) >= 30;
      end
      for (int c = 0; c < 60000 && (n8 < N || ack_l8); c++) begin
        @(posedge clk);
        #1;
        if (ack_l8) ack_l8 = 1'b0;
        else if (req_l8 && n8 < N && $urandom_range(99) >= 30) begin
          ack_l8 = 1'b1;
          din8 = n8;
          n8++;
        end
      end
      for (int c = 0; c < 60000 && rx8 < N; c++) begin
        @(posedge clk);
        #1;
        if (ack_r8) begin
          check("soak8_dout", dout8, rx8);
          rx8++;
        end
        req_r8 = rx8 < N && $urandom_range(99) >= 30;
      end
    join
    req_r = 1'b0;
    req_r8 = 1'b0;
    repeat (3) tick;
    check("soak4_words", rx4, N);
    check("soak8_words", rx8, N);
    check("soak4_err", {31'b0, err}, 0);
    check("soak8_err", {31'b0, err8}, 0);
    check("soak4_count", {29'b0, count}, 0);
    check("soak8_count", {28'b0, count8}, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
